hex8_cpu: RTL and testbench

- Minimal 8-bit accumulator processor in the style of the "Hex" teaching CPU.
- Contains its own 256x8 unified instruction/data memory. The only external pins are clock and reset.
- Each instruction byte is a 4-bit opcode (high nibble) plus a 4-bit operand (low nibble). Wider operands are built with prefix instructions.
- Used as a self-contained core; benches preload and inspect internal state hierarchically.

---
 rtl/hex8_cpu.sv | 140 ++++++++++++++
 tb/tb_hex8_cpu.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/hex8_cpu.sv
// hex8_cpu: 8-bit accumulator core with a unified 256x8 memory.
// Each instruction is a three-clock fetch/decode/execute sequence with nibble prefixes for wide operands.
module hex8_cpu #(
    parameter int MEM_DEPTH = 256
) (
    input logic clk,
    input logic reset
);

    typedef enum logic [3:0] {
        OP_LDAM = 4'h0, OP_LDBM = 4'h1, OP_STAM = 4'h2, OP_LDAP = 4'h3,
        OP_LDAI = 4'h4, OP_LDBI = 4'h5, OP_STAI = 4'h6, OP_BR   = 4'h7,
        OP_BRZ  = 4'h8, OP_BRN  = 4'h9, OP_LDAC = 4'hA, OP_LDBC = 4'hB,
        OP_OPR  = 4'hC, OP_PFIX = 4'hD, OP_NFIX = 4'hE, OP_RSVD = 4'hF
    } opcode_t;

    localparam logic [2:0] FETCH   = 3'b001;
    localparam logic [2:0] DECODE  = 3'b010;
    localparam logic [2:0] EXECUTE = 3'b100;

    logic [7:0] a_reg, b_reg, pc, r_reg;
    logic [3:0] i_reg, o_reg_low, o_reg_high;
    logic [2:0] pipeline, pipeline_next;
    logic [1:0] phi, phi_next;
    logic [7:0] memory [0:MEM_DEPTH-1];

    logic       fetch_en, decode_en, execute_en;
    opcode_t    op;
    logic [7:0] operand, pc_inc, pc_next, read_addr, write_addr, fetch_word;
    logic       taken, mem_we;

    assign op         = opcode_t'(i_reg);
    assign operand    = {o_reg_high, o_reg_low};
    assign pc_inc     = pc + 8'd1;
    assign fetch_word = memory[pc];

    // Sequencer: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipeline <= FETCH;
            phi      <= 2'b01;
        end else begin
            pipeline <= pipeline_next;
            phi      <= phi_next;
        end
    end

    // Sequencer: next state; any illegal encoding recovers to FETCH
    always_comb begin
        phi_next = {phi[0], phi[1]};
        case (pipeline)
            FETCH:   pipeline_next = DECODE;
            DECODE:  pipeline_next = EXECUTE;
            default: pipeline_next = FETCH;
        endcase
    end

    // Sequencer: stage enables
    always_comb begin
        fetch_en   = (pipeline == FETCH);
        decode_en  = (pipeline == DECODE);
        execute_en = (pipeline == EXECUTE);
    end

    always_comb begin
        case (op)
            OP_LDAI: read_addr = a_reg + operand;
            OP_LDBI: read_addr = b_reg + operand;
            default: read_addr = operand;
        endcase
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        taken   = 1'b0;
        pc_next = pc_inc;
        case (op)
            OP_BR:   taken = 1'b1;
            OP_BRZ:  taken = (a_reg == 8'h00);
            OP_BRN:  taken = a_reg[7];
            default: taken = 1'b0;
        endcase
        if (taken)
            pc_next = pc_inc + operand;
        if (op == OP_OPR && operand == 8'd2)
            pc_next = b_reg;
    end

    assign write_addr = (op == OP_STAI) ? b_reg + operand : operand;
    assign mem_we     = execute_en && (op == OP_STAM || op == OP_STAI);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg      <= 8'h00;
            b_reg      <= 8'h00;
            pc         <= 8'h00;
            r_reg      <= 8'h00;
            i_reg      <= 4'h0;
            o_reg_low  <= 4'h0;
            o_reg_high <= 4'h0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            if (fetch_en) begin
                i_reg     <= fetch_word[7:4];
                o_reg_low <= fetch_word[3:0];
            end
            if (decode_en)
                r_reg <= memory[read_addr];
            if (execute_en) begin
                pc <= pc_next;
                case (op)
                    OP_PFIX: o_reg_high <= o_reg_low;
                    OP_NFIX: o_reg_high <= ~o_reg_low;
                    default: o_reg_high <= 4'h0;
                endcase
                case (op)
                    OP_LDAM, OP_LDAI: a_reg <= r_reg;
                    OP_LDBM, OP_LDBI: b_reg <= r_reg;
                    OP_LDAP:          a_reg <= pc_inc + operand;
                    OP_LDAC:          a_reg <= operand;
                    OP_LDBC:          b_reg <= operand;
                    OP_OPR: begin
                        if (operand == 8'd0)
                            a_reg <= a_reg + b_reg;
                        else if (operand == 8'd1)
                            a_reg <= a_reg - b_reg;
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: memory has no reset so its contents survive reset and can be preloaded while reset is held.
    always_ff @(posedge clk) begin
        if (!reset && mem_we)
            memory[write_addr] <= a_reg;
    end

endmodule

// File: tb/tb_hex8_cpu.sv
// Self-checking bench for hex8_cpu: an instruction-level model checked every cycle,
// plus directed programs with hand-computed results.
module tb_hex8_cpu;

    logic clk = 1'b0;
    logic reset;

    hex8_cpu dut (.clk(clk), .reset(reset));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit running  = 1'b0;
    int edges    = 0;

    // Instruction-level architectural model
    logic [7:0] mm [256];
    logic [7:0] ma, mb, mpc;
    logic [3:0] moh;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        logic [7:0] ins, o, nxt, addr;
        logic [3:0] new_oh;
        ins    = mm[mpc];
        o      = {moh, ins[3:0]};
        nxt    = mpc + 8'd1;
        new_oh = 4'h0;
        case (ins[7:4])
            4'h0: ma = mm[o];
            4'h1: mb = mm[o];
            4'h2: mm[o] = ma;
            4'h3: ma = mpc + 8'd1 + o;
            4'h4: begin addr = ma + o; ma = mm[addr]; end
            4'h5: begin addr = mb + o; mb = mm[addr]; end
            4'h6: begin addr = mb + o; mm[addr] = ma; end
            4'h7: nxt = mpc + 8'd1 + o;
            4'h8: if (ma == 8'h00) nxt = mpc + 8'd1 + o;
            4'h9: if (ma[7]) nxt = mpc + 8'd1 + o;
            4'hA: ma = o;
            4'hB: mb = o;
            4'hC: begin
                if (o == 8'd0) ma = ma + mb;
                else if (o == 8'd1) ma = ma - mb;
                else if (o == 8'd2) nxt = mb;
            end
            4'hD: new_oh = ins[3:0];
            4'hE: new_oh = ~ins[3:0];
            default: ;
        endcase
        mpc = nxt;
        moh = new_oh;
    endtask

    // Compare process: sequencing every cycle, architectural state at each instruction boundary
    always @(negedge clk) begin
        logic [2:0] ep;
        int bad, idx;
        if (!running) begin
            edges = 0;
        end else begin
            edges++;
            ep = 3'b001 << (edges % 3);
            check("pipeline", {29'd0, dut.pipeline}, {29'd0, ep});
            check("phi", {30'd0, dut.phi}, (edges % 2 != 0) ? 32'h2 : 32'h1);
            if (edges % 3 == 0) begin
                model_step();
                check("a_reg", {24'd0, dut.a_reg}, {24'd0, ma});
                check("b_reg", {24'd0, dut.b_reg}, {24'd0, mb});
                check("pc", {24'd0, dut.pc}, {24'd0, mpc});
                check("o_reg_high", {28'd0, dut.o_reg_high}, {28'd0, moh});
                bad = -1;
                for (int i = 0; i < 256; i++)
                    if (dut.memory[i] !== mm[i]) bad = i;
                idx = (bad < 0) ? 0 : bad;
                check($sformatf("memory[%0h]", idx), {24'd0, dut.memory[idx]}, {24'd0, mm[idx]});
            end
        end
    end

    task automatic prep(input logic [7:0] fill, input bit rnd);
        logic [7:0] v;
        running = 1'b0;
        reset   = 1'b1;
        @(posedge clk);
        #1;
        ma = 8'h00; mb = 8'h00; mpc = 8'h00; moh = 4'h0;
        for (int i = 0; i < 256; i++) begin
            v = rnd ? 8'($urandom) : fill;
            mm[i] = v;
            dut.memory[i] = v;
        end
    endtask

    task automatic poke(input logic [7:0] addr, input logic [7:0] val);
        mm[addr] = val;
        dut.memory[addr] = val;
    endtask

    task automatic go();
        @(negedge clk);
        #1;
        reset   = 1'b0;
        running = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst a_reg", {24'd0, dut.a_reg}, 32'h0);
        check("rst b_reg", {24'd0, dut.b_reg}, 32'h0);
        check("rst pc", {24'd0, dut.pc}, 32'h0);
        check("rst r_reg", {24'd0, dut.r_reg}, 32'h0);
        check("rst i_reg", {28'd0, dut.i_reg}, 32'h0);
        check("rst o_low", {28'd0, dut.o_reg_low}, 32'h0);
        check("rst o_high", {28'd0, dut.o_reg_high}, 32'h0);
        check("rst pipeline", {29'd0, dut.pipeline}, 32'h1);
        check("rst phi", {30'd0, dut.phi}, 32'h1);

        // Prefetch timing
        prep(8'hF0, 1'b0);
        poke(8'h00, 8'hA5);
        go();
        run(2);
        check("pf o_low", {28'd0, dut.o_reg_low}, 32'h5);
        check("pf i_reg", {28'd0, dut.i_reg}, 32'hA);
        check("pf pc", {24'd0, dut.pc}, 32'h0);
        run(2);
        check("pf pc after", {24'd0, dut.pc}, 32'h1);
        check("pf a_reg", {24'd0, dut.a_reg}, 32'h05);

        // Prefixes
        prep(8'hF0, 1'b0);
        poke(8'h00, 8'hD3); poke(8'h01, 8'hA7);
        go(); run(6);
        check("pfix a_reg", {24'd0, dut.a_reg}, 32'h37);
        prep(8'hF0, 1'b0);
        poke(8'h00, 8'hE3); poke(8'h01, 8'hA7);
        go(); run(6);
        check("nfix a_reg", {24'd0, dut.a_reg}, 32'hC7);
        check("nfix o_high", {28'd0, dut.o_reg_high}, 32'h0);

        // Load/store/ALU: 9 stored to 0F, 9-4 in A, then B reloaded from 0F
        prep(8'hF0, 1'b0);
        poke(8'h00, 8'hA9); poke(8'h01, 8'h2F); poke(8'h02, 8'hB4);
        poke(8'h03, 8'hC1); poke(8'h04, 8'h1F);
        go(); run(6);
        check("stam mem[0F]", {24'd0, dut.memory[8'h0F]}, 32'h09);
        run(6);
        check("sub a_reg", {24'd0, dut.a_reg}, 32'h05);
        run(3);
        check("ldbm b_reg", {24'd0, dut.b_reg}, 32'h09);

        // Branches
        prep(8'hF0, 1'b0);
        poke(8'h00, 8'h82);
        go(); run(3);
        check("brz taken pc", {24'd0, dut.pc}, 32'h03);
        prep(8'hF0, 1'b0);
        poke(8'h00, 8'hA1); poke(8'h01, 8'h82);
        go(); run(6);
        check("brz not taken pc", {24'd0, dut.pc}, 32'h02);
        prep(8'hF0, 1'b0);
        poke(8'h00, 8'hD8); poke(8'h01, 8'hA0); poke(8'h02, 8'h9F);
        go(); run(6);
        check("brn a_reg", {24'd0, dut.a_reg}, 32'h80);
        run(3);
        check("brn taken pc", {24'd0, dut.pc}, 32'h12);
        prep(8'hF0, 1'b0);
        poke(8'h00, 8'hDF); poke(8'h01, 8'h73); poke(8'hF5, 8'h7F);
        go(); run(6);
        check("br long pc", {24'd0, dut.pc}, 32'hF5);
        run(3);
        check("br wrap pc", {24'd0, dut.pc}, 32'h05);

        // Indexed ops with wrapping address sums
        prep(8'hF0, 1'b0);
        poke(8'h00, 8'hDF); poke(8'h01, 8'hBF); poke(8'h02, 8'hD3);
        poke(8'h03, 8'hAC); poke(8'h04, 8'h62); poke(8'h05, 8'h54);
        go(); run(15);
        check("stai mem[01]", {24'd0, dut.memory[8'h01]}, 32'h3C);
        run(3);
        check("ldbi b_reg", {24'd0, dut.b_reg}, 32'hAC);

        // Async reset during EXECUTE of a store
        prep(8'hF0, 1'b0);
        poke(8'h00, 8'hA9); poke(8'h01, 8'h2F); poke(8'h0F, 8'h77);
        go(); run(5);
        running = 1'b0;
        check("pre-reset pipeline", {29'd0, dut.pipeline}, 32'h4);
        reset = 1'b1;
        #1;
        check("async pipeline", {29'd0, dut.pipeline}, 32'h1);
        check("async phi", {30'd0, dut.phi}, 32'h1);
        check("async a_reg", {24'd0, dut.a_reg}, 32'h0);
        check("async pc", {24'd0, dut.pc}, 32'h0);
        check("async i_reg", {28'd0, dut.i_reg}, 32'h0);
        @(posedge clk);
        #1;
        check("aborted store", {24'd0, dut.memory[8'h0F]}, 32'h77);

        // Random programs against the model
        for (int t = 0; t < 20; t++) begin
            prep(8'h00, 1'b1);
            go();
            run(3 * 40);
        end
        running = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
